// File: rtl/bram_axis_pkg.sv
// Shared definitions for the BRAM-to-AXI-Stream row reader.
//   state_t     : reader FSM state encoding
//   DEF_*       : default parameter values used by the reader and its row buffer
//   cnt_width() : counter width for a 0..n-1 range (never less than one bit)
package bram_axis_pkg;

   localparam int DEF_BRAM_ADDR_LENGTH   = 9;
   localparam int DEF_WORD_WIDTH         = 32;
   localparam int DEF_BRAM_WIDTH_IN_WORD = 36;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_axis_if.sv
// AXI-Stream beat channel between the reader and its sink.
//   tdata  : beat payload
//   tvalid : beat present (source)
//   tready : sink accepts this cycle
//   tlast  : final beat of the transfer
// master = stream source (the reader), slave = stream sink.
interface bram_axis_if #(
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_axis_row_buf.sv
// Two-entry row buffer (current + next) with MSW-first word select.
//   clk, rst : clock, synchronous active-high reset (clears both valid flags)
//   load     : din holds a freshly read BRAM row this cycle
//   din      : BRAM row data
//   pop      : the last word of the current row is being accepted
//   sel      : word index within the current row (0 = most significant word)
//   cur_vld  : current row holds data
//   nxt_vld  : next row holds data
//   word     : selected word of the current row, zero while empty
module bram_axis_row_buf
   import bram_axis_pkg::*;
#(
   parameter int WORD_WIDTH         = DEF_WORD_WIDTH,
   parameter int BRAM_WIDTH_IN_WORD = DEF_BRAM_WIDTH_IN_WORD
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       load,
   input  logic [WORD_WIDTH*BRAM_WIDTH_IN_WORD-1:0]   din,
   input  logic                                       pop,
   input  logic [cnt_width(BRAM_WIDTH_IN_WORD)-1:0]   sel,
   output logic                                       cur_vld,
   output logic                                       nxt_vld,
   output logic [WORD_WIDTH-1:0]                      word
);
   localparam int ROW_W = WORD_WIDTH * BRAM_WIDTH_IN_WORD;
   localparam int SEL_W = cnt_width(BRAM_WIDTH_IN_WORD);

   logic [ROW_W-1:0]      cur;
   logic [ROW_W-1:0]      nxt;
   logic [WORD_WIDTH-1:0] words [BRAM_WIDTH_IN_WORD];

   // Word 0 sits in the top bits of the row.
   for (genvar i = 0; i < BRAM_WIDTH_IN_WORD; i++) begin : g_word
      assign words[i] = cur[ROW_W-1-i*WORD_WIDTH -: WORD_WIDTH];
   end

   always_comb begin
      word = '0;
      for (int i = 0; i < BRAM_WIDTH_IN_WORD; i++) begin
         if (cur_vld && sel == SEL_W'(i)) word = words[i];
      end
   end

   // The current slot is free when empty or when its last word leaves this
   // cycle. A waiting next row moves up immediately, so a stream with a
   // ready sink sees no bubble at row boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_vld <= 1'b0;
         nxt_vld <= 1'b0;
      end else if (!cur_vld || pop) begin
         if (nxt_vld) begin
            cur     <= nxt;
            cur_vld <= 1'b1;
            nxt_vld <= load;
            if (load) nxt <= din;
         end else if (load) begin
            cur     <= din;
            cur_vld <= 1'b1;
         end else begin
            cur_vld <= 1'b0;
         end
      end else if (load) begin
         nxt     <= din;
         nxt_vld <= 1'b1;
      end
   end

endmodule

// File: rtl/bram_axis_reader.sv
// Streams a run of BRAM rows out as AXI-Stream words, MSW of each row first.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request, accepted only when idle
//   index_cntl : first row address (latched on accepted start)
//   size_cntl  : row count minus one (latched on accepted start)
//   bram_en    : BRAM read enable, one cycle per row read
//   bram_index : BRAM row address
//   bram_dout  : BRAM row data, valid the cycle after bram_en
//   m_axis     : stream output (tdata/tvalid/tready/tlast)
//   busy       : transfer in progress
//   done       : one-cycle pulse after the final beat is accepted
module bram_axis_reader
   import bram_axis_pkg::*;
#(
   parameter int BRAM_ADDR_LENGTH   = DEF_BRAM_ADDR_LENGTH,
   parameter int WORD_WIDTH         = DEF_WORD_WIDTH,
   parameter int BRAM_WIDTH_IN_WORD = DEF_BRAM_WIDTH_IN_WORD
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [BRAM_ADDR_LENGTH-1:0]              index_cntl,
   input  logic [BRAM_ADDR_LENGTH-1:0]              size_cntl,
   output logic                                     bram_en,
   output logic [BRAM_ADDR_LENGTH-1:0]              bram_index,
   input  logic [WORD_WIDTH*BRAM_WIDTH_IN_WORD-1:0] bram_dout,
   bram_axis_if.master                              m_axis,
   output logic                                     busy,
   output logic                                     done
);
   localparam int A      = BRAM_ADDR_LENGTH;
   localparam int WCNT_W = cnt_width(BRAM_WIDTH_IN_WORD);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BRAM_WIDTH_IN_WORD - 1);

   state_t            state;
   // vld_pipe[0]: read issued this cycle (drives bram_en)
   // vld_pipe[1]: bram_dout carries that read's row this cycle
   logic [1:0]        vld_pipe;
   logic [A-1:0]      rd_left;      // rows still to be read after the last issued one
   logic [A-1:0]      stream_left;  // rows still to stream after the current one
   logic [WCNT_W-1:0] wcnt;
   logic              cur_vld;
   logic              nxt_vld;
   logic [WORD_WIDTH-1:0] word;

   logic accept, last_word, pop, prefetch;

   assign accept    = cur_vld && m_axis.tready;
   assign last_word = (wcnt == LAST_WORD);
   assign pop       = accept && last_word;
   // One read in flight at most, and only into an empty next slot; stops
   // once the final row has been requested.
   assign prefetch  = (state == ST_STREAM) && cur_vld && !nxt_vld &&
                      (vld_pipe == 2'b00) && (rd_left != '0);

   assign bram_en       = vld_pipe[0];
   assign m_axis.tvalid = cur_vld;
   assign m_axis.tdata  = word;
   assign m_axis.tlast  = cur_vld && last_word && (stream_left == '0);

   bram_axis_row_buf #(
      .WORD_WIDTH         (WORD_WIDTH),
      .BRAM_WIDTH_IN_WORD (BRAM_WIDTH_IN_WORD)
   ) u_row_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (vld_pipe[1]),
      .din     (bram_dout),
      .pop     (pop),
      .sel     (wcnt),
      .cur_vld (cur_vld),
      .nxt_vld (nxt_vld),
      .word    (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         vld_pipe    <= 2'b00;
         bram_index  <= '0;
         rd_left     <= '0;
         stream_left <= '0;
         wcnt        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         vld_pipe[0] <= 1'b0;
         done        <= 1'b0;

         if (accept) wcnt <= last_word ? '0 : wcnt + WCNT_W'(1);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  // The first row read goes out in the cycle right after start.
                  bram_index  <= index_cntl;
                  vld_pipe[0] <= 1'b1;
                  rd_left     <= size_cntl;
                  stream_left <= size_cntl;
                  wcnt        <= '0;
                  busy        <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // Leave once the first row is on bram_dout; it lands in the
               // current slot on this same edge.
               if (vld_pipe[1]) state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (prefetch) begin
                  vld_pipe[0] <= 1'b1;
                  bram_index  <= bram_index + A'(1);  // wraps at 2^A
                  rd_left     <= rd_left - A'(1);
               end
               if (pop) begin
                  if (stream_left == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     stream_left <= stream_left - A'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bram_axis_reader.md
BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

Interface
REQ-001 SHALL have parameter BRAM_ADDR_LENGTH, default 9, BRAM address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, AXIS beat width in bits.
REQ-003 SHALL have parameter BRAM_WIDTH_IN_WORD, default 36, AXIS words per BRAM row; row width = WORD_WIDTH*BRAM_WIDTH_IN_WORD.
REQ-004 SHALL have one clock and synchronous, active-high reset, ports: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have ports: index_cntl  input  BRAM_ADDR_LENGTH  first row address, sampled on accepted start.
REQ-007 SHALL have ports: size_cntl  input  BRAM_ADDR_LENGTH  row count minus one, sampled on accepted start.
REQ-008 SHALL have ports: bram_en  output  1  BRAM read enable.
REQ-009 SHALL have ports: bram_index  output  BRAM_ADDR_LENGTH  BRAM read address.
REQ-010 SHALL have ports: bram_dout  input  row width  BRAM read data, valid one cycle after bram_en.
REQ-011 SHALL have ports: m_axis_tdata  output  WORD_WIDTH; m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tlast  output  1.
REQ-012 SHALL have ports: busy  output  1  transfer in progress; done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, STREAM, DONE.
REQ-014 IDLE: start=1 SHALL latch index_cntl/size_cntl, go FETCH, busy=1 next cycle; start while busy SHALL be ignored.
REQ-015 FETCH: SHALL drive bram_en=1 for exactly one cycle at the first row address, capture bram_dout the following cycle into the current-row buffer, then enter STREAM.
REQ-016 STREAM: m_axis_tdata SHALL present word k of the current row, word 0 = bits [row_width-1 : row_width-WORD_WIDTH] (MSW first), word k advancing only on tvalid&&tready.
REQ-017 SHALL hold tvalid, tdata, tlast stable while tvalid=1 and tready=0.
REQ-018 SHALL prefetch: once current row is loaded and the next-row buffer is empty and rows remain, issue one bram_en read of the next address; data captured into next-row buffer one cycle later.
REQ-019 On acceptance of word BRAM_WIDTH_IN_WORD-1: if next-row buffer valid, SHALL move it to current with no bubble (tvalid stays 1); else tvalid=0 until data arrives.
REQ-020 Row addresses SHALL increment modulo 2^BRAM_ADDR_LENGTH (511+1 = 0 at default).
REQ-021 Total rows SHALL be size_cntl+1; m_axis_tlast=1 only on word BRAM_WIDTH_IN_WORD-1 of the final row.
REQ-022 Accepted final beat SHALL move FSM to DONE; DONE SHALL pulse done=1 for one cycle, busy=0, and return to IDLE.
REQ-023 With tready held 1, throughput SHALL be one beat per cycle after the first beat; first tvalid SHALL rise 3 cycles after accepted start.
REQ-024 bram_en SHALL be 0 whenever no read is issued; BRAM SHALL never be read beyond the final row.

Reset
REQ-025 rst=1 SHALL force IDLE, bram_en=0, bram_index=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, both buffer-valid flags 0, word counter 0, on the next clock edge.
REQ-026 rst asserted mid-transfer SHALL abandon the transfer with no done pulse; a start after rst deasserts SHALL behave as from power-up.

Structure
REQ-027 Shared package bram_axis_pkg SHALL hold the FSM state encoding and default parameter constants.
REQ-028 The two-entry row buffer (current/next, valid flags, MSW-first word select) SHALL be sub-module bram_axis_row_buf; FSM, address and word counters stay in the top.

Verification
REQ-029 index_cntl=5, size_cntl=1, tready=1 -> bram_index reads 5 then 6, 72 consecutive beats, tlast on beat 72 only, done pulse one cycle later.
REQ-030 Same transfer, tready toggling 1/0 every cycle -> 72 beats with data identical to the tready=1 run, tdata/tlast stable in every stalled cycle.
REQ-031 index_cntl=511, size_cntl=1 -> reads at 511 then 0, 72 beats, tlast on beat 72.
REQ-032 start re-pulsed at beat 10 with index_cntl=100 -> ignored; transfer completes from original address with original count.
REQ-033 rst asserted at beat 40 -> next cycle tvalid=0, busy=0, bram_en=0, no done; subsequent start index_cntl=0, size_cntl=0 -> 36 beats, tlast on beat 36.
REQ-034 Row pattern word k = row*64+k, size_cntl=3, tready=1 -> 144 beats in 144 cycles with no bubble at row boundaries, values in MSW-first order.
